io_writeback_scheduler: RTL
===========================

// Module: io_writeback_scheduler
// PURPOSE
//  Shares the single register-writeback port of the IO subsystem among all IO response sources:
//  clock generator, timers and port controllers.
//  Round-robin arbiter feeding a 2-entry output buffer; replaces the stateless writeback mux.
//  Sits between the per-device writeback handshakes and the core's IO writeback stage.
// PARAMETERS
//  DATABITWIDTH     16  writeback data width
//  PORTCOUNT        14  number of response sources (12 clock/timer + IO devices)
//  REGADDRBITWIDTH  4   destination-register field width
//  PRIOPORTS        4   ports [PRIOPORTS-1:0] get strict priority (only with IOWB_PRIORITY_EN)
// PORTS
//  sys_clk     in   1                             system clock (only clock)
//  async_rst   in   1                             reset: asynchronous, active-low
//  clk_en      in   1                             global clock enable
//  InputACK    in   PORTCOUNT                     per-source valid
//  InputREQ    out  PORTCOUNT                     per-source ready (one-hot or zero)
//  InputData   in   PORTCOUNT x DATABITWIDTH      per-source data
//  InputAddr   in   PORTCOUNT x REGADDRBITWIDTH   per-source destination register
//  OutputACK   out  1                             writeback valid
//  OutputREQ   in   1                             writeback ready from core
//  OutputData  out  DATABITWIDTH                  head-entry data
//  OutputAddr  out  REGADDRBITWIDTH               head-entry destination register
//  GrantPort   out  $clog2(PORTCOUNT)             index of source accepted this cycle (debug)
// BEHAVIOUR
//  - Transfer = ACK && REQ on the same sys_clk edge, with clk_en=1. Nothing changes state while clk_en=0.
//  - Reset (async_rst=0), effective immediately:
//    - buffer flushed, count=0, RR pointer=0
//    - InputREQ=0, OutputACK=0, OutputData=0, OutputAddr=0, GrantPort=0
//  - Reset asserted mid-transfer discards buffered entries; no partial writeback is emitted.
//  - Space = (count<2). No combinational path from OutputREQ to InputREQ.
//  - Arbitration (combinational, each cycle):
//    - search InputACK starting at RR pointer, wrapping at PORTCOUNT-1 -> 0
//    - first set bit wins; InputREQ[win]=Space && clk_en; all other REQ bits 0
//  - On an accepted transfer:
//    - {InputAddr,InputData}[win] written to the tail
//    - RR pointer <= win+1, wrapping PORTCOUNT-1 -> 0
//    - GrantPort=win that cycle
//    - the pointer does not move without a transfer
//  - Buffer count 0..2; OutputACK = (count!=0); Output* driven from the head, registered.
//  - Latency: source accept at edge N -> OutputACK high after edge N (visible cycle N+1).
//  - Simultaneous push+pop at count=1: count stays 1, new entry becomes head next cycle.
//    - Push at count=2 is impossible (Space=0).
//    - Pop at count=0 is ignored.
//  - Sustained throughput: 1 writeback/cycle while OutputREQ=1.
//  - Ordering: entries leave in acceptance order; no two sources are accepted in one cycle.
//  - No starvation: every asserted source is granted within PORTCOUNT accepted transfers.
// CONFIGURATION
//  - IOWB_PRIORITY_EN defined:
//    - if any InputACK[PRIOPORTS-1:0] is set, the lowest such index wins
//    - the RR pointer is unchanged by priority grants
//    - other ports use round-robin only when no priority port requests
//  - Undefined: pure round-robin over all ports.
// STRUCTURE
//  - io_pkg:
//    - typedef wb_entry_t {logic [REGADDRBITWIDTH-1:0] dest; logic [DATABITWIDTH-1:0] data;}
//    - IO_REGADDRBITWIDTH=4 constant
//    - function rr_next(ptr,count) for wraparound
//  - Sub-module io_rr_picker: combinational rotate-priority pick (req vector, pointer -> onehot, index, any).
//  - Top holds the 2-entry buffer, count and pointer.
// TESTING
//  1. Reset: async_rst=0 mid-stream with count=2 -> OutputACK=0 and InputREQ=0 at once; after release count=0, ptr=0.
//  2. Single source: port 5 ACK, data 16'hBEEF, dest 3, OutputREQ=1
//     -> OutputACK next cycle with BEEF/3; GrantPort=5; ptr=6.
//  3. All 14 ports requesting continuously, OutputREQ=1
//     -> grants 0,1,...,13,0 in order, one writeback per cycle, no gaps.
//  4. Backpressure: OutputREQ=0, ports 2 and 9 requesting -> two accepts, then InputREQ=0.
//     OutputREQ=1 -> outputs port 2 data then port 9 data.
//  5. Wraparound: ptr=13, requests on ports 1 and 13 -> 13 granted first, ptr=0, then 1.
//  6. IOWB_PRIORITY_EN: ports 3 and 10 requesting with ptr=4 -> 3 always wins, ptr stays 4.
//     Without the macro: 10 wins first.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared types and helpers for the IO writeback scheduler.
// Provides the buffered writeback entry type and round-robin wrap helper.
package io_pkg;

    localparam int IO_DATABITWIDTH    = 16;
    localparam int IO_REGADDRBITWIDTH = 4;

    typedef struct packed {
        logic [IO_REGADDRBITWIDTH-1:0] dest;
        logic [IO_DATABITWIDTH-1:0]    data;
    } wb_entry_t;

    // Next round-robin position after ptr, wrapping count-1 -> 0.
    function automatic int rr_next(input int ptr, input int count);
        return (ptr + 1 >= count) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/io_writeback_scheduler_if.sv
// io_writeback_scheduler_if: per-source writeback handshakes plus the
// single core-side writeback port. slave = scheduler, master = environment.
interface io_writeback_scheduler_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int PORTCOUNT       = 14,
    parameter int REGADDRBITWIDTH = 4
);
    logic [PORTCOUNT-1:0]                      InputACK;
    logic [PORTCOUNT-1:0]                      InputREQ;
    logic [PORTCOUNT-1:0][DATABITWIDTH-1:0]    InputData;
    logic [PORTCOUNT-1:0][REGADDRBITWIDTH-1:0] InputAddr;
    logic                                      OutputACK;
    logic                                      OutputREQ;
    logic [DATABITWIDTH-1:0]                   OutputData;
    logic [REGADDRBITWIDTH-1:0]                OutputAddr;

    modport slave (
        input  InputACK, InputData, InputAddr, OutputREQ,
        output InputREQ, OutputACK, OutputData, OutputAddr
    );

    modport master (
        output InputACK, InputData, InputAddr, OutputREQ,
        input  InputREQ, OutputACK, OutputData, OutputAddr
    );
endinterface

// File: rtl/io_rr_picker.sv
// io_rr_picker: combinational rotate-priority pick. Searches i_req from
// i_ptr upward with wrap; ports i_req, i_ptr -> o_onehot, o_idx, o_any.
module io_rr_picker #(
    parameter int N  = 14,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    always_comb begin
        int j;
        j        = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_any && i_req[IW'(j)]) begin
                o_any              = 1'b1;
                o_idx              = IW'(j);
                o_onehot[IW'(j)]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_writeback_scheduler.sv
// io_writeback_scheduler: round-robin arbiter over PORTCOUNT sources into a
// 2-entry writeback buffer. Ports: sys_clk, async_rst (async, active-low),
// clk_en, wb (slave handshake bundle), GrantPort (debug accepted index).
// Optional IOWB_PRIORITY_EN: ports [PRIOPORTS-1:0] win by fixed priority.
module io_writeback_scheduler
    import io_pkg::*;
#(
    parameter int DATABITWIDTH    = IO_DATABITWIDTH,
    parameter int PORTCOUNT       = 14,
    parameter int REGADDRBITWIDTH = IO_REGADDRBITWIDTH,
    parameter int PRIOPORTS       = 4
) (
    input  logic                         sys_clk,
    input  logic                         async_rst,
    input  logic                         clk_en,
    io_writeback_scheduler_if.slave      wb,
    output logic [$clog2(PORTCOUNT)-1:0] GrantPort
);
    localparam int IW = $clog2(PORTCOUNT);

`ifdef IOWB_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic [1:0]           r_count;
    logic [IW-1:0]        r_ptr;
    wb_entry_t            r_buf [2];

    logic [PORTCOUNT-1:0] w_prio_mask;
    logic [PORTCOUNT-1:0] w_rr_onehot;
    logic [PORTCOUNT-1:0] w_pr_onehot;
    logic [PORTCOUNT-1:0] w_win_onehot;
    logic [IW-1:0]        w_rr_idx;
    logic [IW-1:0]        w_pr_idx;
    logic [IW-1:0]        w_win_idx;
    logic                 w_rr_any;
    logic                 w_pr_any;
    logic                 w_space;
    logic                 w_req_en;
    logic                 w_push;
    logic                 w_pop;
    wb_entry_t            w_new;

    always_comb begin
        w_prio_mask = '0;
        for (int i = 0; i < PORTCOUNT; i++)
            w_prio_mask[i] = PRIO_EN && (i < PRIOPORTS);
    end

    io_rr_picker #(.N(PORTCOUNT), .IW(IW)) u_rr (
        .i_req    (wb.InputACK),
        .i_ptr    (r_ptr),
        .o_onehot (w_rr_onehot),
        .o_idx    (w_rr_idx),
        .o_any    (w_rr_any)
    );

    // Fixed-priority pick is a rotate pick anchored at port 0.
    io_rr_picker #(.N(PORTCOUNT), .IW(IW)) u_prio (
        .i_req    (wb.InputACK & w_prio_mask),
        .i_ptr    ('0),
        .o_onehot (w_pr_onehot),
        .o_idx    (w_pr_idx),
        .o_any    (w_pr_any)
    );

    assign w_win_onehot = w_pr_any ? w_pr_onehot : w_rr_onehot;
    assign w_win_idx    = w_pr_any ? w_pr_idx : w_rr_idx;

    // Space depends only on registered count: no OutputREQ->InputREQ path.
    assign w_space  = (r_count != 2'd2);
    assign w_req_en = w_space && clk_en && async_rst;
    assign w_push   = w_req_en && w_rr_any;
    assign w_pop    = clk_en && (r_count != 2'd0) && wb.OutputREQ;

    assign wb.InputREQ = w_req_en ? w_win_onehot : '0;
    assign GrantPort   = w_push ? w_win_idx : '0;

    assign w_new.dest = wb.InputAddr[w_win_idx];
    assign w_new.data = wb.InputData[w_win_idx];

    assign wb.OutputACK  = (r_count != 2'd0);
    assign wb.OutputData = r_buf[0].data;
    assign wb.OutputAddr = r_buf[0].dest;

    always_ff @(posedge sys_clk or negedge async_rst) begin
        if (!async_rst) begin
            r_count  <= 2'd0;
            r_ptr    <= '0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (clk_en) begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_buf[0] <= w_new;
                    else                 r_buf[1] <= w_new;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_count  <= r_count - 2'd1;
                end
                // Push needs count<2, pop needs count>0: count is 1 here.
                2'b11: r_buf[0] <= w_new;
                default: ;
            endcase
            if (w_push && !w_pr_any)
                r_ptr <= IW'(rr_next(int'(w_win_idx), PORTCOUNT));
        end
    end
endmodule
